// File: rtl/collatz_host.sv
// Host for the byte-wide Collatz core: writes the seed, pulses start, waits out busy, reads orbit/path.
// Optional watchdog on the busy wait is enabled by defining COLLATZ_HOST_TIMEOUT_EN.
module collatz_host #(
    parameter int BITS           = 64,
    parameter int OLEN_BITS      = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [BITS-1:0]      start_value,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [OLEN_BITS-1:0] result_orbit_len,
    output logic [OLEN_BITS-1:0] result_orbit_delta,
    output logic [BITS-1:0]      result_path_record,
    output logic                 result_timeout,
    output logic [7:0]           dut_ui_in,
    output logic [7:0]           dut_uio_in,
    input  logic [7:0]           dut_uo_out,
    input  logic [7:0]           dut_uio_out,
    input  logic [7:0]           dut_uio_oe
);
    localparam int WB = BITS / 8;
    localparam int OB = OLEN_BITS / 8;
    localparam int RB = OB + WB;

    typedef enum logic [2:0] {
        IDLE, WRITE, START, WAIT_ACK, POLL, READ_SET, READ_CAP, DONE
    } state_t;

    state_t                state, state_n;
    logic [BITS-1:0]       seed, seed_n;
    logic [3:0]            widx, widx_n;
    logic [7:0]            ridx, ridx_n;
    logic [OLEN_BITS-1:0]  orbit_buf, orbit_n, prev_raw, prev_n, len_n, delta_n;
    logic [BITS-1:0]       path_buf, path_n, rec_n;
    logic [OLEN_BITS+7:0]  orbit_sh;
    logic [BITS+7:0]       path_sh;
    logic                  ready_n, valid_n, tmo_n, timed_out;
    logic [7:0]            ui_n, uio_n;

    // Busy status mirror and the unused oe bits carry no information the host needs.
    logic unused_io;
    assign unused_io = ^{dut_uio_out, dut_uio_oe[6:0], (TIMEOUT_CYCLES != 0)};

    function automatic logic [7:0] rd_ctrl(input logic [7:0] idx);
        logic [3:0] a;
        a = idx[3:0] - 4'(OB);
        if (idx < 8'(OB)) rd_ctrl = {4'h0, idx[3:0]};
        else              rd_ctrl = {4'h1, a};
    endfunction

`ifdef COLLATZ_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                  tcnt <= '0;
        else if (state == START)                    tcnt <= '0;
        else if (state == WAIT_ACK || state == POLL) tcnt <= tcnt + 1'b1;
    end

    assign timed_out = (state == WAIT_ACK || state == POLL) && (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        seed_n   = seed;
        widx_n   = widx;
        ridx_n   = ridx;
        orbit_n  = orbit_buf;
        path_n   = path_buf;
        prev_n   = prev_raw;
        ready_n  = 1'b0;
        valid_n  = result_valid;
        len_n    = result_orbit_len;
        delta_n  = result_orbit_delta;
        rec_n    = result_path_record;
        tmo_n    = result_timeout;
        ui_n     = 8'h00;
        uio_n    = 8'h00;
        orbit_sh = {dut_uo_out, orbit_buf};
        path_sh  = {dut_uo_out, path_buf};
        unique case (state)
            IDLE: begin
                if (start_valid && start_ready) begin
                    seed_n  = start_value;
                    widx_n  = '0;
                    ui_n    = start_value[7:0];
                    uio_n   = 8'h80;
                    state_n = WRITE;
                end else begin
                    ready_n = 1'b1;
                end
            end
            WRITE: begin
                if (widx == 4'(WB - 1)) begin
                    uio_n   = 8'h40;
                    state_n = START;
                end else begin
                    widx_n = widx + 4'd1;
                    seed_n = seed >> 8;
                    ui_n   = seed_n[7:0];
                    uio_n  = {4'h8, widx_n};
                end
            end
            START: state_n = WAIT_ACK;
            WAIT_ACK, POLL: begin
                if (timed_out) begin
                    // Abort leaves the previous raw count untouched so the next delta stays meaningful.
                    state_n = DONE;
                    valid_n = 1'b1;
                    tmo_n   = 1'b1;
                    len_n   = '0;
                    delta_n = '0;
                    rec_n   = '0;
                end else if (state == WAIT_ACK && dut_uio_oe[7]) begin
                    state_n = POLL;
                end else if (state == POLL && !dut_uio_oe[7]) begin
                    ridx_n  = '0;
                    uio_n   = rd_ctrl(8'd0);
                    state_n = READ_SET;
                end
            end
            READ_SET: begin
                uio_n   = dut_uio_in;
                state_n = READ_CAP;
            end
            READ_CAP: begin
                // Bytes arrive LSB first, so shift each one in from the top.
                if (ridx < 8'(OB)) orbit_n = orbit_sh[OLEN_BITS+7:8];
                else               path_n  = path_sh[BITS+7:8];
                if (ridx == 8'(RB - 1)) begin
                    len_n   = orbit_buf;
                    delta_n = orbit_buf - prev_raw;
                    prev_n  = orbit_buf;
                    rec_n   = path_n;
                    tmo_n   = 1'b0;
                    valid_n = 1'b1;
                    state_n = DONE;
                end else begin
                    ridx_n  = ridx + 8'd1;
                    uio_n   = rd_ctrl(ridx_n);
                    state_n = READ_SET;
                end
            end
            DONE: begin
                if (result_ready) begin
                    valid_n = 1'b0;
                    ready_n = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            seed               <= '0;
            widx               <= '0;
            ridx               <= '0;
            orbit_buf          <= '0;
            path_buf           <= '0;
            prev_raw           <= '0;
            start_ready        <= 1'b0;
            result_valid       <= 1'b0;
            result_orbit_len   <= '0;
            result_orbit_delta <= '0;
            result_path_record <= '0;
            result_timeout     <= 1'b0;
            dut_ui_in          <= 8'h00;
            dut_uio_in         <= 8'h00;
        end else begin
            state              <= state_n;
            seed               <= seed_n;
            widx               <= widx_n;
            ridx               <= ridx_n;
            orbit_buf          <= orbit_n;
            path_buf           <= path_n;
            prev_raw           <= prev_n;
            start_ready        <= ready_n;
            result_valid       <= valid_n;
            result_orbit_len   <= len_n;
            result_orbit_delta <= delta_n;
            result_path_record <= rec_n;
            result_timeout     <= tmo_n;
            dut_ui_in          <= ui_n;
            dut_uio_in         <= uio_n;
        end
    end
endmodule
